// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the two-input gate checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } state_e;

  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_XOR = 4'b0110;

  localparam logic [1:0] LastVec = 2'd3;

endpackage

// File: rtl/gate_tt_checker.sv
// Drives all four input vectors into an external 2-input gate and scores its output
// against a truth table, sampling once per vector after DWELL cycles.
module gate_tt_checker
  import gate_chk_pkg::*;
#(
  // Left untyped so a mis-sized truth table is caught below instead of silently resized.
  parameter     TT    = TT_OR,
  parameter int DWELL = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_c,
  output logic       a_o,
  output logic       b_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] err_mask
);

  if (DWELL < 1 || $bits(TT) != 4) begin : g_param_err
    $error("gate_tt_checker: DWELL must be >= 1 and TT must be exactly 4 bits");
  end

  localparam int unsigned    CntW    = $clog2(DWELL + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);
  localparam logic [3:0]     TtVec   = TT;

  state_e          state_q;
  logic [1:0]      vec_q;
  logic [CntW-1:0] cnt_q;
  logic            a_q, b_q, busy_q, done_q, pass_q;
  logic [2:0]      err_cnt_q;
  logic [3:0]      err_mask_q;

  logic       mismatch;
  logic [2:0] err_cnt_nxt;
  logic [1:0] vec_inc;

  // Only meaningful on the compare edge; dut_c is ignored on every other cycle.
  assign mismatch    = (dut_c != TtVec[vec_q]);
  assign err_cnt_nxt = err_cnt_q + {2'b00, mismatch};
  assign vec_inc     = vec_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      cnt_q      <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_mask_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StDrive;
            vec_q      <= '0;
            cnt_q      <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_mask_q <= '0;
          end
        end
        StDrive: begin
          if (cnt_q == CntLast) begin
            err_cnt_q  <= err_cnt_nxt;
            err_mask_q <= err_mask_q | (4'(mismatch) << vec_q);
            cnt_q      <= '0;
            if (vec_q == LastVec) begin
              state_q <= StDone;
              vec_q   <= '0;
              a_q     <= 1'b0;
              b_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_nxt == 3'd0);
            end else begin
              vec_q <= vec_inc;
              a_q   <= vec_inc[1];
              b_q   <= vec_inc[0];
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign a_o      = a_q;
  assign b_o      = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_mask = err_mask_q;

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 Parameter TT, default 4'b1110 (OR): expected output per vector, bit index = {a,b}.
REQ-002 Parameter DWELL, default 5: clock cycles each input vector is held before the output is sampled.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 start  input  1  one-cycle request to run a full check; honoured only in IDLE or DONE.
REQ-006 dut_c  input  1  output of the 2-input gate under test.
REQ-007 a_o  output  1  stimulus to gate input a.
REQ-008 b_o  output  1  stimulus to gate input b.
REQ-009 busy  output  1  high while vectors are being applied.
REQ-010 done  output  1  high from run completion until next accepted start or reset.
REQ-011 pass  output  1  high with done when err_cnt==0; low otherwise.
REQ-012 err_cnt  output  3  number of mismatching vectors in last run (0..4).
REQ-013 err_mask  output  4  bit i set if vector i ({a,b}=i) mismatched.

Function
REQ-014 The block has FSM states IDLE, DRIVE and DONE, and all outputs are registered.
REQ-015 In IDLE or DONE with start=1, the next cycle enters DRIVE with vec=0, a_o=0, b_o=0 and busy=1, and clears done, pass, err_cnt and err_mask.
REQ-016 In DRIVE, {a_o,b_o}=vec and a dwell counter counts 0..DWELL-1.
REQ-017 At the edge where the dwell counter equals DWELL-1, dut_c is compared with TT[vec], and on mismatch err_mask[vec] is set and err_cnt is incremented.
REQ-018 After the vec=0..2 compare edges, vec increments and the dwell counter returns to 0.
REQ-019 After the vec=3 compare edge, the FSM enters DONE with busy=0, done=1 and pass=(final err_cnt==0), and the sampled result of vec=3 is included in err_cnt, err_mask and pass.
REQ-020 Vector order is 00, 01, 10, 11, and a run lasts exactly 4*DWELL busy cycles.
REQ-021 a_o and b_o return to 0 on leaving DRIVE.
REQ-022 start is ignored while busy=1, and the run continues unaffected.
REQ-023 start in DONE restarts the run on the next cycle per REQ-015.
REQ-024 dut_c is sampled only on compare edges, so glitches or X on other cycles do not affect results.
REQ-025 DWELL<1 or TT width other than 4 is an elaboration-time error.
REQ-026 The dwell counter width is $clog2(DWELL+1) and it does not wrap within a vector.

Reset
REQ-027 With rst_n=0 at a clock edge, the FSM enters IDLE, vec and the dwell counter are cleared, and a_o, b_o, busy, done, pass, err_cnt and err_mask are all driven to 0.
REQ-028 Reset asserted mid-run aborts the run immediately with no partial results retained, and start is ignored during reset.
REQ-029 After reset, the block remains in IDLE until the first start with rst_n=1.

Structure
REQ-030 Package gate_chk_pkg holds the state enum and truth-table constants TT_OR=4'b1110, TT_AND=4'b1000 and TT_XOR=4'b0110.
REQ-031 The block is a single module with no sub-modules, and the gate under test is instantiated by the bench rather than inside the checker.

Verification
REQ-032 (OR pass) With DUT orgate, TT=TT_OR, DWELL=5 and one start pulse, the bench shall observe busy for 20 cycles, {a_o,b_o}=00/01/10/11 for 5 cycles each, then done=1, pass=1, err_cnt=0 and err_mask=4'b0000.
REQ-033 (Mismatch) With DUT orgate, TT=TT_AND and DWELL=5, the bench shall observe done=1, pass=0, err_cnt=2 and err_mask=4'b0110.
REQ-034 (Stuck output) With dut_c tied to 1 and TT=TT_OR, the bench shall observe err_mask=4'b0001 and err_cnt=1, and with dut_c tied to 0 it shall observe err_mask=4'b1110 and err_cnt=3.
REQ-035 (Start handling) start pulsed in cycle 7 of a run shall be ignored, with the run still ending after 20 busy cycles, and start in DONE shall clear results and rerun identically.
REQ-036 (Reset mid-run) rst_n=0 for one edge during vec=2 shall yield IDLE on the next cycle with all outputs 0 and no done pulse.
REQ-037 (DWELL=1 edge) With DWELL=1, TT=TT_XOR and DUT orgate, the bench shall observe 4 busy cycles, err_mask=4'b1000 and err_cnt=1.
